// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared encodings and sizing helper for the round-robin ALU scheduler.
package alu_sched_pkg;
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_MUL = 1'b1;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: request/response bundle between requester FSMs and alu_rr_scheduler.
interface alu_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W = 8
);
  localparam int IDW = alu_sched_pkg::idw(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_op;
  logic [NREQ-1:0] req_lock;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0] rsp_data;
  logic busy;
  modport master (
    output req_valid, req_op, req_lock, req_a, req_b,
    input req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
  modport slave (
    input req_valid, req_op, req_lock, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible request at or above ptr, wrapping.
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_elig,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);
  int w_j;
  logic [IDW-1:0] w_jx;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j = 0;
    w_jx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(i_ptr) + k;
      w_j = (w_j >= NREQ) ? w_j - NREQ : w_j;
      w_jx = IDW'(w_j);
      if (!o_any && i_req[w_jx] && i_elig[w_jx]) begin
        o_any = 1'b1;
        o_gnt[w_jx] = 1'b1;
        o_idx = w_jx;
      end
    end
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one W-bit add/multiply ALU among NREQ requesters in round-robin order.
// Define ALU_SCHED_LOCK_EN to let a requester hold the grant across a multi-op sequence.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W = 8
) (
  input logic clk,
  input logic resetn,
  alu_rr_scheduler_if.slave bus
);
  localparam int IDW = idw(NREQ);
  state_t r_state, w_next;
  logic [IDW-1:0] r_ptr, r_id, w_idx;
  logic r_op;
  logic [W-1:0] r_a, r_b, r_res;
  logic [NREQ-1:0] w_gnt, w_elig;
  logic w_any, w_accept;
  logic [2*W-1:0] w_prod;
  logic [W-1:0] w_a [NREQ];
  logic [W-1:0] w_b [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_a[i] = bus.req_a[i*W +: W];
    assign w_b[i] = bus.req_b[i*W +: W];
  end
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (bus.req_valid),
    .i_elig(w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );
`ifdef ALU_SCHED_LOCK_EN
  logic r_locked;
  logic [IDW-1:0] r_owner;
  assign w_elig = r_locked ? NREQ'(1) << r_owner : '1;
  // only the owner can be accepted while locked, so its req_lock alone decides the next lock state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_locked <= 1'b0;
      r_owner <= '0;
    end else if (w_accept) begin
      r_locked <= bus.req_lock[w_idx];
      r_owner <= w_idx;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^bus.req_lock;
  assign w_elig = '1;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = S_IDLE;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = w_any;
        w_next = w_any ? S_EXEC : S_IDLE;
      end
      S_EXEC: w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  assign w_prod = r_a * r_b;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
      r_id <= '0;
      r_op <= ALU_OP_ADD;
      r_a <= '0;
      r_b <= '0;
      r_res <= '0;
    end else begin
      if (w_accept) begin
        r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        r_id <= w_idx;
        r_op <= bus.req_op[w_idx];
        r_a <= w_a[w_idx];
        r_b <= w_b[w_idx];
      end
      if (r_state == S_EXEC) r_res <= (r_op == ALU_OP_MUL) ? w_prod[W-1:0] : r_a + r_b;
    end
  end
  // ready is gated by resetn so all outputs read 0 while reset is held
  assign bus.req_ready = (w_accept && resetn) ? w_gnt : '0;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id = bus.rsp_valid ? r_id : '0;
  assign bus.rsp_data = bus.rsp_valid ? r_res : '0;
  assign bus.busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed and random stimulus against a queue-based scheduling model.
module tb_alu_rr_scheduler;
  typedef struct {
    int id;
    int data;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb[$];
  int got_id[$];
  int got_data[$];
  int m_ptr = 0;
  int m_busy = 0;
  int m_owner = 0;
  bit m_locked = 1'b0;
  exp_t e;

  alu_rr_scheduler_if #(.NREQ(4), .W(8)) bus ();
  alu_rr_scheduler #(.NREQ(4), .W(8)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit elig(input int c);
    return !m_locked || c == m_owner;
  endfunction

  // apply one cycle of inputs and advance the model: a free ALU takes the first eligible
  // valid requester counting upward from the round-robin pointer
  task automatic drive(input logic [3:0] v, input logic [3:0] op, input logic [3:0] lk,
                       input logic [31:0] a, input logic [31:0] b);
    logic [3:0] er;
    int g, c, x, y;
    bit bsy;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_op = op;
    bus.req_lock = lk;
    bus.req_a = a;
    bus.req_b = b;
    #1;
    er = '0;
    g = -1;
    bsy = m_busy > 0;
    if (bsy) m_busy--;
    else begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (g < 0 && v[c] && elig(c)) g = c;
      end
      if (g >= 0) begin
        x = int'(a[g*8 +: 8]);
        y = int'(b[g*8 +: 8]);
        er[g] = 1'b1;
        sb.push_back('{g, op[g] ? (x * y) % 256 : (x + y) % 256, cyc + 2});
        m_ptr = (g + 1) % 4;
        m_busy = 2;
`ifdef ALU_SCHED_LOCK_EN
        m_locked = lk[g];
        m_owner = g;
`endif
      end
    end
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("busy", 32'(bus.busy), 32'(bsy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'h0, 4'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset(input bit mid);
    if (mid) begin
      @(posedge clk);
      #2;
    end else @(negedge clk);
    bus.req_valid = '0;
    resetn = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    sb.delete();
    m_ptr = 0;
    m_busy = 0;
    m_locked = 1'b0;
    m_owner = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic clear_log();
    got_id.delete();
    got_data.delete();
  endtask

  // any response must match the head of the scoreboard on the exact predicted cycle
  initial forever begin
    @(negedge clk);
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
      got_id.push_back(int'(bus.rsp_id));
      got_data.push_back(int'(bus.rsp_data));
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      chk("rsp_missing", 0, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_lock = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    #1 resetn = 1'b0;
    #2;
    chk("init_req_ready", 32'(bus.req_ready), 0);
    chk("init_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("init_rsp_id", 32'(bus.rsp_id), 0);
    chk("init_rsp_data", 32'(bus.rsp_data), 0);
    chk("init_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    clear_log();
    drive(4'b0001, 4'b0000, 4'h0, 32'h0000_000F, 32'h0000_0001);
    idle(3);
    chk("add_count", 32'(got_id.size()), 1);
    if (got_id.size() == 1) begin
      chk("add_id", 32'(got_id[0]), 0);
      chk("add_data", 32'(got_data[0]), 32'h10);
    end

    clear_log();
    drive(4'b0100, 4'b0100, 4'h0, 32'h0020_0000, 32'h0010_0000);
    idle(2);
    drive(4'b0100, 4'b0100, 4'h0, 32'h000C_0000, 32'h000B_0000);
    idle(3);
    chk("mul_count", 32'(got_id.size()), 2);
    if (got_id.size() == 2) begin
      chk("mul_id0", 32'(got_id[0]), 2);
      chk("mul_trunc", 32'(got_data[0]), 32'h00);
      chk("mul_id1", 32'(got_id[1]), 2);
      chk("mul_data", 32'(got_data[1]), 32'h84);
    end

    do_reset(1'b0);
    clear_log();
    for (int i = 0; i < 24; i++) drive(4'b1111, 4'($urandom), 4'h0, $urandom, $urandom);
    idle(3);
    chk("fair_count", 32'(got_id.size()), 8);
    for (int i = 0; i < got_id.size() && i < 8; i++) chk("fair_order", 32'(got_id[i]), 32'(i % 4));

    clear_log();
    drive(4'b1000, 4'b1000, 4'h0, $urandom, $urandom);
    do_reset(1'b1);
    idle(3);
    chk("midrst_no_rsp", 32'(got_id.size()), 0);
    drive(4'b1000, 4'b0000, 4'h0, $urandom, $urandom);
    idle(3);
    drive(4'b1111, 4'b0000, 4'h0, $urandom, $urandom);
    do_reset(1'b1);
    drive(4'b1111, 4'b0000, 4'h0, $urandom, $urandom);
    idle(3);
    chk("midrst_count", 32'(got_id.size()), 2);
    if (got_id.size() == 2) begin
      chk("sole_req3", 32'(got_id[0]), 3);
      chk("all_valid_req0", 32'(got_id[1]), 0);
    end

    clear_log();
    drive(4'b0001, 4'b0000, 4'h0, $urandom, $urandom);
    idle(3);
    for (int i = 0; i < 4; i++)
      repeat (3) drive(4'b0111, 4'($urandom), (i < 2) ? 4'b0010 : 4'b0000, $urandom, $urandom);
    idle(3);
    chk("lock_count", 32'(got_id.size()), 5);
    if (got_id.size() == 5) begin
`ifdef ALU_SCHED_LOCK_EN
      chk("lock_g0", 32'(got_id[1]), 1);
      chk("lock_g1", 32'(got_id[2]), 1);
      chk("lock_g2", 32'(got_id[3]), 1);
      chk("lock_g3", 32'(got_id[4]), 2);
`else
      chk("nolock_g0", 32'(got_id[1]), 1);
      chk("nolock_g1", 32'(got_id[2]), 2);
      chk("nolock_g2", 32'(got_id[3]), 0);
      chk("nolock_g3", 32'(got_id[4]), 1);
`endif
    end

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset(1'b1);
      drive(4'($urandom), 4'($urandom), 4'($urandom & $urandom & $urandom), $urandom, $urandom);
    end
    idle(4);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
